// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer:
// FSM state encodings, opcode class codes and opcode range boundaries.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_LINK    = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  // ALU opcodes occupy two ranges; 6'h07 sits in the gap and is illegal.
  localparam logic [5:0] OP_ALU_A_HI = 6'h06;
  localparam logic [5:0] OP_ALU_B_LO = 6'h08;
  localparam logic [5:0] OP_ALU_B_HI = 6'h10;
  localparam logic [5:0] OP_LOAD     = 6'h11;
  localparam logic [5:0] OP_STORE    = 6'h12;
  localparam logic [5:0] OP_LINK_A   = 6'h13;
  localparam logic [5:0] OP_LINK_B   = 6'h14;
  localparam logic [5:0] OP_JUMP_LO  = 6'h15;
  localparam logic [5:0] OP_JUMP_HI  = 6'h19;

endpackage

// File: rtl/mc_sequencer_op_class_dec.sv
// Combinational opcode classifier: maps the 6-bit opcode to its class.
module op_class_dec
  import mc_sequencer_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  op_cls
);

  // Range compare; anything not matched falls through as illegal.
  always_comb begin
    op_cls = CLS_ILLEGAL;
    if (op <= OP_ALU_A_HI)
      op_cls = CLS_ALU;
    else if ((op >= OP_ALU_B_LO) && (op <= OP_ALU_B_HI))
      op_cls = CLS_ALU;
    else if (op == OP_LOAD)
      op_cls = CLS_LOAD;
    else if (op == OP_STORE)
      op_cls = CLS_STORE;
    else if ((op == OP_LINK_A) || (op == OP_LINK_B))
      op_cls = CLS_LINK;
    else if ((op >= OP_JUMP_LO) && (op <= OP_JUMP_HI))
      op_cls = CLS_JUMP;
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM,
// strobe decode and retired-instruction counter.
// Build option: ILLEGAL_HALT_EN -- when defined, an illegal opcode parks the
// FSM in HALT until reset; otherwise it retires as a NOP.
//
// state  | meaning
// FETCH  | request instruction word, load IR on mem_ready
// DECODE | capture opcode into op_q
// EXEC   | dispatch on class; jumps (and NOP'd illegals) retire here
// MEM    | data access; stores retire on mem_ready
// WB     | register write-back and retire
// HALT   | parked after an illegal opcode, exits only via reset
module mc_sequencer
  import mc_sequencer_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        inst_done,
  output logic [2:0]  state,
  output logic [31:0] inst_cnt
);

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  op_q;
  op_class_t   op_cls;
  logic [31:0] cnt_q;

  op_class_dec u_op_class_dec (
    .op     (op_q),
    .op_cls (op_cls)
  );

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  // Opcode is captured once in DECODE so later changes on the IR field are ignored.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst)                    op_q <= '0;
    else if (state_q == ST_DECODE)  op_q <= opcode;
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst)        cnt_q <= '0;
    else if (inst_done) cnt_q <= cnt_q + 32'd1;
  end

  // Next-state and strobe decode; reset suppresses every strobe combinationally.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    inst_done = 1'b0;
    if (!cpu_rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC: begin
          case (op_cls)
            CLS_ALU, CLS_LINK:   state_d = ST_WB;
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_JUMP: begin
              pc_we     = 1'b1;
              inst_done = 1'b1;
              state_d   = ST_FETCH;
            end
            default: begin
`ifdef ILLEGAL_HALT_EN
              state_d   = ST_HALT;
`else
              pc_we     = 1'b1;
              inst_done = 1'b1;
              state_d   = ST_FETCH;
`endif
            end
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_cls == CLS_STORE);
          if (mem_ready) begin
            if (op_cls == CLS_LOAD) begin
              state_d = ST_WB;
            end else begin
              pc_we     = 1'b1;
              inst_done = 1'b1;
              state_d   = ST_FETCH;
            end
          end
        end
        ST_WB: begin
          rf_we     = 1'b1;
          pc_we     = 1'b1;
          inst_done = 1'b1;
          state_d   = ST_FETCH;
        end
`ifdef ILLEGAL_HALT_EN
        ST_HALT: state_d = ST_HALT;
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign state    = cpu_rst ? ST_FETCH : state_q;
  assign inst_cnt = cpu_rst ? 32'd0 : cnt_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer. Expected per-cycle outputs come from
// an instruction-level trace generator (class + wait counts -> cycle list).
module tb_mc_sequencer;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, rf_we, inst_done;
  logic [2:0]  state;
  logic [31:0] inst_cnt;

  mc_sequencer dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .inst_done (inst_done),
    .state     (state),
    .inst_cnt  (inst_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic        req, we, ir, pc, rf, done;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    string   name;
    longint  got;
    longint  want;
  } lit_t;

  exp_t        exp_q[$];
  lit_t        lit_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  logic [31:0] model_cnt = 32'd0;
  exp_t        ce;
  lit_t        cl;

  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_LINK = 3, C_JUMP = 4, C_ILL = 5;

  function automatic int classify(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v <= 6 || (v >= 8 && v <= 16)) return C_ALU;
    if (v == 17) return C_LOAD;
    if (v == 18) return C_STORE;
    if (v == 19 || v == 20) return C_LINK;
    if (v >= 21 && v <= 25) return C_JUMP;
    return C_ILL;
  endfunction

  // One clock cycle: drive inputs on the falling edge and queue what the
  // outputs must show during this cycle.
  task automatic cyc(input logic [5:0] opc, input logic rdy, input logic rst,
                     input logic [2:0] st, input logic req, input logic we,
                     input logic ir, input logic pc, input logic rf,
                     input logic done, input logic preload);
    exp_t e;
    @(negedge cpu_clk);
    opcode    = opc;
    mem_ready = rdy;
    cpu_rst   = rst;
    if (preload) begin
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      model_cnt = 32'hFFFF_FFFF;
    end
    e.idx = ncyc; e.st = st; e.req = req; e.we = we; e.ir = ir;
    e.pc = pc; e.rf = rf; e.done = done;
    e.cnt = rst ? 32'd0 : model_cnt;
    exp_q.push_back(e);
    if (rst)       model_cnt = 32'd0;
    else if (done) model_cnt = model_cnt + 32'd1;
    ncyc++;
  endtask

  task automatic lit(input string name, input longint got, input longint want);
    lit_t l;
    l.name = name; l.got = got; l.want = want;
    lit_q.push_back(l);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle trace of one instruction; the live opcode is scrambled
  // after DECODE and mem_ready is randomised where it must be ignored.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic pre, output int n);
    int          start, cls;
    logic        st_w;
    logic [5:0]  g;
    start = ncyc;
    cls   = classify(op);
    g     = ~op;
    st_w  = (cls == C_STORE);
    for (int i = 0; i < fw; i++)
      cyc(op, 1'b0, 1'b0, 3'd0, 1, 0, 0, 0, 0, 0, pre && i == 0);
    cyc(op, 1'b1, 1'b0, 3'd0, 1, 0, 1, 0, 0, 0, 1'b0);
    cyc(op, rnd(), 1'b0, 3'd1, 0, 0, 0, 0, 0, 0, 1'b0);
    case (cls)
      C_JUMP: cyc(g, rnd(), 1'b0, 3'd2, 0, 0, 0, 1, 0, 1, 1'b0);
      C_ILL: begin
`ifdef ILLEGAL_HALT_EN
        cyc(g, rnd(), 1'b0, 3'd2, 0, 0, 0, 0, 0, 0, 1'b0);
`else
        cyc(g, rnd(), 1'b0, 3'd2, 0, 0, 0, 1, 0, 1, 1'b0);
`endif
      end
      C_ALU, C_LINK: begin
        cyc(g, rnd(), 1'b0, 3'd2, 0, 0, 0, 0, 0, 0, 1'b0);
        cyc(g, rnd(), 1'b0, 3'd4, 0, 0, 0, 1, 1, 1, 1'b0);
      end
      default: begin
        cyc(g, rnd(), 1'b0, 3'd2, 0, 0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < mw; i++)
          cyc(g, 1'b0, 1'b0, 3'd3, 1, st_w, 0, 0, 0, 0, 1'b0);
        cyc(g, 1'b1, 1'b0, 3'd3, 1, st_w, 0, st_w, 0, st_w, 1'b0);
        if (!st_w)
          cyc(g, rnd(), 1'b0, 3'd4, 0, 0, 0, 1, 1, 1, 1'b0);
      end
    endcase
    n = ncyc - start;
  endtask

  // Single compare process: per-cycle output records, then literal pins.
  always @(negedge cpu_clk) begin
    #2;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      checks++;
      if ({state, mem_req, mem_we, ir_we, pc_we, rf_we, inst_done, inst_cnt} !==
          {ce.st, ce.req, ce.we, ce.ir, ce.pc, ce.rf, ce.done, ce.cnt}) begin
        errors++;
        $display("FAIL cycle%0d state/req/we/ir/pc/rf/done/cnt got %0d %b%b%b%b%b%b %h exp %0d %b%b%b%b%b%b %h",
                 ce.idx, state, mem_req, mem_we, ir_we, pc_we, rf_we, inst_done, inst_cnt,
                 ce.st, ce.req, ce.we, ce.ir, ce.pc, ce.rf, ce.done, ce.cnt);
      end
    end
    while (lit_q.size() > 0) begin
      cl = lit_q.pop_front();
      checks++;
      if (cl.got != cl.want) begin
        errors++;
        $display("FAIL %s got %0d exp %0d", cl.name, cl.got, cl.want);
      end
    end
  end

  initial begin
    int n;
    // Reset
    cyc(6'h00, 1'b1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 1'b1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0);

    run_instr(6'h00, 0, 0, 1'b0, n); lit("alu_latency", n, 4);
    lit("alu_cnt", longint'(model_cnt), 1);
    run_instr(6'h11, 0, 3, 1'b0, n); lit("load_wait_latency", n, 8);
    run_instr(6'h16, 0, 0, 1'b0, n); lit("jump_latency", n, 3);
    run_instr(6'h12, 0, 0, 1'b0, n); lit("store_latency", n, 4);
    run_instr(6'h11, 0, 0, 1'b0, n); lit("load_latency", n, 5);
    run_instr(6'h13, 0, 0, 1'b0, n); lit("link_latency", n, 4);
    run_instr(6'h10, 2, 0, 1'b0, n); lit("alu_hi_fetch_wait", n, 6);
    run_instr(6'h19, 0, 0, 1'b0, n);
    run_instr(6'h14, 1, 0, 1'b0, n);
    run_instr(6'h12, 1, 2, 1'b0, n); lit("store_wait_latency", n, 7);
    run_instr(6'h15, 0, 0, 1'b0, n);
    lit("cnt_after_11", longint'(model_cnt), 11);

    // Reset during the MEM wait of a store
    cyc(6'h12, 1'b1, 1'b0, 3'd0, 1, 0, 1, 0, 0, 0, 1'b0);
    cyc(6'h12, 1'b0, 1'b0, 3'd1, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 1'b0, 1'b0, 3'd3, 1, 1, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 1'b1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 1'b0, 1'b0, 3'd0, 1, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 1'b0, 1'b0, 3'd0, 1, 0, 0, 0, 0, 0, 1'b0);

    // Counter wrap
    run_instr(6'h08, 1, 0, 1'b1, n);
    lit("wrap_cnt", longint'(model_cnt), 0);

    // Illegal opcodes
`ifdef ILLEGAL_HALT_EN
    run_instr(6'h3F, 0, 0, 1'b0, n); lit("illegal_to_halt", n, 3);
    for (int i = 0; i < 6; i++)
      cyc(6'($urandom_range(0, 63)), rnd(), 1'b0, 3'd5, 0, 0, 0, 0, 0, 0, 1'b0);
    lit("halt_cnt", longint'(model_cnt), 0);
    cyc(6'h00, 1'b0, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    run_instr(6'h00, 0, 0, 1'b0, n); lit("alu_after_halt", n, 4);
`else
    run_instr(6'h3F, 0, 0, 1'b0, n); lit("illegal_nop_latency", n, 3);
    run_instr(6'h07, 0, 0, 1'b0, n); lit("illegal_gap_latency", n, 3);
    lit("illegal_cnt", longint'(model_cnt), 2);
    run_instr(6'h00, 0, 0, 1'b0, n);
`endif

    for (int i = 0; i < 20 && (exp_q.size() > 0 || lit_q.size() > 0); i++)
      @(negedge cpu_clk);
    @(negedge cpu_clk);
    #5;
    if (exp_q.size() > 0 || lit_q.size() > 0) begin
      $display("FAIL drain pending got %0d exp 0", exp_q.size() + lit_q.size());
      $fatal(1, "check queue did not drain");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
